// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the framebuffer port-B arbiter.
package fb_pkg;

  localparam int unsigned FB_W = 320;
  localparam int unsigned FB_H = 200;
  localparam int unsigned X_W  = 9;
  localparam int unsigned Y_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_ISSUE = 3'b010,
    S_WAIT  = 3'b100
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first unmasked request at or above ptr, wrapping mod NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [NREQ-1:0] cand;

  assign cand = req & ~mask;

  always_comb begin
    int j;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      j = (int'(ptr) + k) % int'(NREQ);
      if (!valid && cand[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fb_port_b_arbiter.sv
// Round-robin arbiter sharing framebuffer RAM port B between NREQ pixel requesters,
// with per-request bounds checking and single-transaction RAM handshake sequencing.
module fb_port_b_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned FB_W = fb_pkg::FB_W,
  parameter int unsigned FB_H = fb_pkg::FB_H
) (
  input  logic                         clk_b,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              req_we,
  input  logic [NREQ*fb_pkg::X_W-1:0]  req_x,
  input  logic [NREQ*fb_pkg::Y_W-1:0]  req_y,
  input  logic [NREQ-1:0]              req_wdata,
  output logic [NREQ-1:0]              ack,
  output logic                         err,
  output logic                         rdata,
  output logic [fb_pkg::X_W-1:0]       ram_x,
  output logic [fb_pkg::Y_W-1:0]       ram_y,
  output logic                         ram_read,
  output logic                         ram_write,
  output logic                         ram_in,
  input  logic                         ram_out,
  input  logic                         ram_rdy
);

  import fb_pkg::*;

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam logic [X_W:0] XLIM = (X_W + 1)'(FB_W);
  localparam logic [Y_W:0] YLIM = (Y_W + 1)'(FB_H);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic              rdata_q, rdata_d;
  logic [X_W-1:0]    ram_x_q, ram_x_d;
  logic [Y_W-1:0]    ram_y_q, ram_y_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic              ram_in_q, ram_in_d;

  logic [X_W-1:0]    x_arr [NREQ];
  logic [Y_W-1:0]    y_arr [NREQ];
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              pick_oor;

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      x_arr[i] = req_x[i*X_W +: X_W];
      y_arr[i] = req_y[i*Y_W +: Y_W];
    end
  end

  // ack_q masks the requester being acked this cycle; it has not yet dropped req.
  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (req),
    .mask  (ack_q),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign pick_oor = ({1'b0, x_arr[pick_idx]} >= XLIM) || ({1'b0, y_arr[pick_idx]} >= YLIM);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    we_d        = we_q;
    ack_d       = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    ram_x_d     = ram_x_q;
    ram_y_d     = ram_y_q;
    ram_read_d  = ram_read_q;
    ram_write_d = ram_write_q;
    ram_in_d    = ram_in_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          idx_d    = pick_idx;
          we_d     = req_we[pick_idx];
          rr_ptr_d = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          if (pick_oor) begin
            // Out-of-range requests complete immediately without touching the RAM.
            ack_d[pick_idx] = 1'b1;
            err_d           = 1'b1;
          end else begin
            ram_x_d     = x_arr[pick_idx];
            ram_y_d     = y_arr[pick_idx];
            ram_in_d    = req_wdata[pick_idx];
            ram_read_d  = ~req_we[pick_idx];
            ram_write_d = req_we[pick_idx];
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (ram_rdy) begin
          ram_read_d  = 1'b0;
          ram_write_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ram_rdy) begin
          ack_d[idx_q] = 1'b1;
          if (!we_q) rdata_d = ram_out;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_b) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= 1'b0;
      ram_x_q     <= '0;
      ram_y_q     <= '0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_in_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ram_x_q     <= ram_x_d;
      ram_y_q     <= ram_y_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_in_q    <= ram_in_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign ram_x     = ram_x_q;
  assign ram_y     = ram_y_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_in    = ram_in_q;

endmodule

// File: tb/tb_fb_port_b_arbiter.sv
// Self-checking bench: RAM port-B model plus a transaction-level arbitration/pixel reference.
module tb_fb_port_b_arbiter;

  localparam int NREQ = 4;
  localparam int FB_W = 320;
  localparam int FB_H = 200;

  logic              clk_b = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, req_we, req_wdata, ack;
  logic [NREQ*9-1:0] req_x;
  logic [NREQ*8-1:0] req_y;
  logic              err, rdata, ram_read, ram_write, ram_in, ram_out, ram_rdy;
  logic [8:0]        ram_x;
  logic [7:0]        ram_y;

  always #5 clk_b = ~clk_b;

  fb_port_b_arbiter #(
    .NREQ (NREQ),
    .FB_W (FB_W),
    .FB_H (FB_H)
  ) dut (
    .clk_b     (clk_b),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_wdata (req_wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .ram_x     (ram_x),
    .ram_y     (ram_y),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_in    (ram_in),
    .ram_out   (ram_out),
    .ram_rdy   (ram_rdy)
  );

  // RAM port-B model: rdy low 1 cycle after a write, 2 after a read; out updated on return.
  bit ram_mem [FB_W*FB_H];
  int ram_cnt;
  int ram_addr;
  bit ram_is_rd;
  int ram_addr_now;

  assign ram_addr_now = int'(ram_y) * FB_W + int'(ram_x);

  always @(posedge clk_b) begin
    if (reset) begin
      ram_rdy <= 1'b1;
      ram_cnt <= 0;
      ram_out <= 1'b0;
    end else if (ram_rdy && (ram_read || ram_write)) begin
      ram_rdy   <= 1'b0;
      ram_cnt   <= ram_write ? 1 : 2;
      ram_addr  <= ram_addr_now;
      ram_is_rd <= ram_read;
      if (ram_write && ram_addr_now < FB_W*FB_H) ram_mem[ram_addr_now] <= ram_in;
    end else if (!ram_rdy) begin
      if (ram_cnt <= 1) begin
        ram_rdy <= 1'b1;
        if (ram_is_rd && ram_addr < FB_W*FB_H) ram_out <= ram_mem[ram_addr];
      end else begin
        ram_cnt <= ram_cnt - 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requester side
  bit [NREQ-1:0] pend, linger, hold, acked_now;
  logic          t_we [NREQ];
  logic          t_wd [NREQ];
  logic [8:0]    t_x  [NREQ];
  logic [7:0]    t_y  [NREQ];

  // Reference model: one transaction in flight, fixed latencies, round-robin over pending
  bit   ref_mem [FB_W*FB_H];
  bit   m_busy;
  int   m_ack_cyc, m_idx, m_ptr;
  bit   m_err, m_we, m_wd, m_rdata;
  int   m_x, m_y;
  int   n_w, n_r;
  int   ack_log [$];

  task automatic raise(input int i, input bit we, input int x, input int y, input bit wd,
                       input bit hold_it);
    pend[i] = 1'b1;
    t_we[i] = we;
    t_x[i]  = 9'(x);
    t_y[i]  = 8'(y);
    t_wd[i] = wd;
    hold[i] = hold_it;
  endtask

  task automatic raise_rand(input int i);
    int x, y;
    case ($urandom_range(0, 9))
      0: begin
        case ($urandom_range(0, 2))
          0:       x = 319;
          1:       x = 320;
          default: x = 511;
        endcase
        y = $urandom_range(0, 3);
      end
      1: begin
        case ($urandom_range(0, 2))
          0:       y = 199;
          1:       y = 200;
          default: y = 255;
        endcase
        x = $urandom_range(0, 7);
      end
      default: begin
        x = $urandom_range(0, 7);
        y = $urandom_range(0, 3);
      end
    endcase
    raise(i, bit'($urandom_range(0, 1)), x, y, bit'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0);
  endtask

  task automatic commit();
    int j;
    for (int i = 0; i < NREQ; i++) begin
      req[i]         = pend[i] | linger[i];
      req_we[i]      = t_we[i];
      req_wdata[i]   = t_wd[i];
      req_x[i*9 +: 9] = t_x[i];
      req_y[i*8 +: 8] = t_y[i];
    end
    if (!reset && !m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (!m_busy && pend[j]) begin
          m_busy = 1'b1;
          m_idx  = j;
          m_we   = t_we[j];
          m_wd   = t_wd[j];
          m_x    = int'(t_x[j]);
          m_y    = int'(t_y[j]);
          m_err  = (m_x >= FB_W) || (m_y >= FB_H);
          m_ack_cyc = cyc + (m_err ? 1 : (m_we ? 4 : 5));
          m_ptr  = (j + 1) % NREQ;
          n_w    = 0;
          n_r    = 0;
          if (!m_err && m_we) ref_mem[m_y*FB_W + m_x] = m_wd;
        end
      end
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] exp_ack;
    @(posedge clk_b);
    #1;
    cyc++;
    linger    = '0;
    acked_now = '0;
    exp_ack   = '0;
    if (m_busy && cyc == m_ack_cyc) exp_ack[m_idx] = 1'b1;
    check_eq("ack", 32'(ack), 32'(exp_ack));
    if (!m_busy) begin
      check_eq("idle_strobe", 32'({ram_read, ram_write}), 32'h0);
    end else begin
      if (ram_write) n_w++;
      if (ram_read)  n_r++;
      if (!m_err && (n_w + n_r) > 0) begin
        check_eq("ram_x", 32'(ram_x), 32'(m_x));
        check_eq("ram_y", 32'(ram_y), 32'(m_y));
        if (m_we) check_eq("ram_in", 32'(ram_in), 32'(m_wd));
      end
      if (cyc == m_ack_cyc) begin
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("n_write_strobes", 32'(n_w), 32'((!m_err && m_we) ? 1 : 0));
        check_eq("n_read_strobes", 32'(n_r), 32'((!m_err && !m_we) ? 1 : 0));
        if (!m_we && !m_err) m_rdata = ref_mem[m_y*FB_W + m_x];
        m_busy = 1'b0;
        ack_log.push_back(m_idx);
        pend[m_idx]      = 1'b0;
        acked_now[m_idx] = 1'b1;
        if (hold[m_idx]) begin
          linger[m_idx] = 1'b1;
          hold[m_idx]   = 1'b0;
        end
      end
    end
    check_eq("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic tick();
    commit();
    step();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pend   = '0;
    linger = '0;
    hold   = '0;
    m_busy = 1'b0;
    m_ptr  = 0;
    m_rdata = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_ack", 32'(ack), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    check_eq("rst_ram_read", 32'(ram_read), 32'h0);
    check_eq("rst_ram_write", 32'(ram_write), 32'h0);
    check_eq("rst_ram_x", 32'(ram_x), 32'h0);
    check_eq("rst_ram_y", 32'(ram_y), 32'h0);
    check_eq("rst_ram_in", 32'(ram_in), 32'h0);
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((m_busy || pend != '0) && n < max) begin
      tick();
      n++;
    end
    if (m_busy || pend != '0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: transaction open after %0d cycles, required completion", max);
      m_busy = 1'b0;
      pend   = '0;
    end
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    pend = '0; linger = '0; hold = '0; acked_now = '0;
    m_busy = 1'b0; m_ptr = 0; m_rdata = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      t_we[i] = 1'b0; t_wd[i] = 1'b0; t_x[i] = '0; t_y[i] = '0;
    end
    do_reset();

    // Single write, then readback
    ack_log.delete();
    raise(0, 1'b1, 5, 3, 1'b1, 1'b0);
    run_idle(20);
    raise(0, 1'b0, 5, 3, 1'b0, 1'b0);
    run_idle(20);
    check_eq("t2_rdata", 32'(rdata), 32'h1);
    check_eq("t12_acks", 32'(ack_log.size()), 32'h2);

    // Range errors on each axis boundary
    ack_log.delete();
    raise(1, 1'b1, 320, 0, 1'b1, 1'b0);
    run_idle(20);
    raise(1, 1'b0, 0, 200, 1'b0, 1'b0);
    run_idle(20);
    check_eq("t3_acks", 32'(ack_log.size()), 32'h2);

    // Fairness with all four re-raised after each ack
    do_reset();
    ack_log.delete();
    for (int i = 0; i < NREQ; i++) raise(i, bit'($urandom_range(0, 1)), $urandom_range(0, 7),
                                         $urandom_range(0, 3), bit'($urandom_range(0, 1)), 1'b0);
    for (int c = 0; c < 200 && ack_log.size() < 8; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && !linger[i] && !acked_now[i])
          raise(i, bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3),
                bit'($urandom_range(0, 1)), 1'b0);
      tick();
    end
    pend = '0;
    run_idle(20);
    check_eq("t4_count", 32'(ack_log.size() >= 8), 32'h1);
    for (int k = 0; k < 8 && k < ack_log.size(); k++)
      check_eq("t4_order", 32'(ack_log[k]), 32'(k % NREQ));

    // req2 held through its ack while req3 pending: req3 next
    do_reset();
    ack_log.delete();
    raise(2, 1'b1, 1, 1, 1'b1, 1'b1);
    tick();
    raise(3, 1'b1, 2, 1, 1'b0, 1'b0);
    run_idle(30);
    check_eq("t5a_count", 32'(ack_log.size()), 32'h2);
    if (ack_log.size() == 2) begin
      check_eq("t5a_first", 32'(ack_log[0]), 32'h2);
      check_eq("t5a_second", 32'(ack_log[1]), 32'h3);
    end

    // req2 held alone through ack: must not be regranted in the ack cycle
    do_reset();
    ack_log.delete();
    raise(2, 1'b0, 1, 1, 1'b0, 1'b1);
    run_idle(30);
    check_eq("t5b_count", 32'(ack_log.size()), 32'h1);

    // Reset while waiting on a read: no ack, then a fresh read completes
    do_reset();
    ack_log.delete();
    raise(0, 1'b0, 5, 3, 1'b0, 1'b0);
    tick();
    tick();
    do_reset();
    repeat (6) tick();
    check_eq("t6_no_ack", 32'(ack_log.size()), 32'h0);
    raise(0, 1'b0, 5, 3, 1'b0, 1'b0);
    run_idle(20);
    check_eq("t6_acks", 32'(ack_log.size()), 32'h1);
    check_eq("t6_rdata", 32'(rdata), 32'h1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && !linger[i] && !acked_now[i] && $urandom_range(0, 3) == 0)
          raise_rand(i);
      tick();
    end
    run_idle(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
